// File: rtl/top_decoder_pkg.sv
// Shared types and helpers for the handshaked binary-to-one-hot decoder.
package top_decoder_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 1 << DEF_IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic [DEF_OUT_W-1:0] onehot(input logic [DEF_IN_W-1:0] code);
    onehot       = '0;
    onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (head + skid) with a registered
// in_ready, so upstream ready never combinationally depends on out_ready.
module decoder_skid_buf
  import top_decoder_pkg::*;
#(
  parameter int W = DEF_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         state;
  logic [W-1:0] skid;
  logic         accept;
  logic         drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // NOTE: the data registers are reset and cleared on drain because the
  // downstream contract is out_data == 0 whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (!accept && drain) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (accept && drain) begin
            out_data <= in_data;
          end
        end
        TWO: begin
          if (drain) begin
            out_data <= skid;
            skid     <= '0;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_data  <= '0;
          skid      <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/top_decoder_handshake.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer.
// Optional odd-parity check on the input code: DECODER_PARITY_EN.
module top_decoder_handshake
  import top_decoder_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int CNT_W = 16,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d,
  input  logic             valid_in,
`ifdef DECODER_PARITY_EN
  input  logic             par,
`endif
  output logic             ready_out,
  output logic [OUT_W-1:0] q,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] dec_cnt
`ifdef DECODER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  logic [OUT_W-1:0] dec;
  logic             par_ok;

  if (IN_W == DEF_IN_W) begin : g_pkg_dec
    assign dec = onehot(d);
  end else begin : g_gen_dec
    assign dec = OUT_W'(1) << d;
  end

`ifdef DECODER_PARITY_EN
  assign par_ok = ^{d, par};

  // A bad word still completes the handshake; it is only kept out of the buffer.
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= valid_in & ready_out & ~par_ok;
  end
`else
  assign par_ok = 1'b1;
`endif

  decoder_skid_buf #(.W(OUT_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (dec),
    .in_valid  (valid_in & par_ok),
    .in_ready  (ready_out),
    .out_data  (q),
    .out_valid (valid_out),
    .out_ready (ready_in)
  );

  always_ff @(posedge clk) begin
    if (rst)                        dec_cnt <= '0;
    else if (valid_out && ready_in) dec_cnt <= dec_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_top_decoder_handshake.sv
// Directed bench for top_decoder_handshake: vector table plus hand sequences
// for backpressure reset, counter wrap and (when enabled) DECODER_PARITY_EN.
module tb_top_decoder_handshake;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  d;
  logic        valid_in;
  logic        ready_in;
  logic        par;
  logic        ready_out,  ready_out_w;
  logic [7:0]  q,          q_w;
  logic        valid_out,  valid_out_w;
  logic [15:0] dec_cnt;
  logic [3:0]  dec_cnt_w;
  logic        par_err,    par_err_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  top_decoder_handshake #(.IN_W(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .valid_in  (valid_in),
`ifdef DECODER_PARITY_EN
    .par       (par),
`endif
    .ready_out (ready_out),
    .q         (q),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .dec_cnt   (dec_cnt)
`ifdef DECODER_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  top_decoder_handshake #(.IN_W(3), .CNT_W(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .valid_in  (valid_in),
`ifdef DECODER_PARITY_EN
    .par       (par),
`endif
    .ready_out (ready_out_w),
    .q         (q_w),
    .valid_out (valid_out_w),
    .ready_in  (ready_in),
    .dec_cnt   (dec_cnt_w)
`ifdef DECODER_PARITY_EN
    ,
    .par_err   (par_err_w)
`endif
  );

`ifndef DECODER_PARITY_EN
  assign par_err   = 1'b0;
  assign par_err_w = 1'b0;
`endif

  typedef struct {
    logic        vin;
    logic [2:0]  d;
    logic        rin;
    logic [7:0]  q;
    logic        vout;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic vin, input logic [2:0] dd, input logic rin,
                              input logic [7:0] eq, input logic ev, input logic er,
                              input logic [15:0] ec);
    vec_t v;
    v.vin = vin; v.d = dd; v.rin = rin;
    v.q = eq; v.vout = ev; v.rdy = er; v.cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs are those seen just after the edge that samples the inputs.
    tbl[0]  = mk(1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1, 16'd0);
    tbl[1]  = mk(1'b1, 3'd1, 1'b1, 8'h02, 1'b1, 1'b1, 16'd1);
    tbl[2]  = mk(1'b1, 3'd2, 1'b1, 8'h04, 1'b1, 1'b1, 16'd2);
    tbl[3]  = mk(1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 1'b1, 16'd3);
    tbl[4]  = mk(1'b1, 3'd4, 1'b1, 8'h10, 1'b1, 1'b1, 16'd4);
    tbl[5]  = mk(1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1, 16'd5);
    tbl[6]  = mk(1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b1, 16'd6);
    tbl[7]  = mk(1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1, 16'd7);
    tbl[8]  = mk(1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd8);
    // Backpressure: 3 and 5 fill the buffer, 6 is held off until a slot frees.
    tbl[9]  = mk(1'b1, 3'd3, 1'b0, 8'h08, 1'b1, 1'b1, 16'd8);
    tbl[10] = mk(1'b1, 3'd5, 1'b0, 8'h08, 1'b1, 1'b0, 16'd8);
    tbl[11] = mk(1'b1, 3'd6, 1'b0, 8'h08, 1'b1, 1'b0, 16'd8);
    tbl[12] = mk(1'b1, 3'd6, 1'b1, 8'h20, 1'b1, 1'b1, 16'd9);
    tbl[13] = mk(1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b1, 16'd10);
    tbl[14] = mk(1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd11);

    rst = 1'b1; d = 3'd0; valid_in = 1'b0; ready_in = 1'b0; par = 1'b0;
    step();
    step();
    check("reset_q",         32'(q),         32'h00);
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_ready_out", 32'(ready_out), 32'd1);
    check("reset_dec_cnt",   32'(dec_cnt),   32'd0);
    check("reset_par_err",   32'(par_err),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      valid_in = tbl[i].vin;
      d        = tbl[i].d;
      ready_in = tbl[i].rin;
      step();
      check($sformatf("vec%0d_q", i),         32'(q),         32'(tbl[i].q));
      check($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].vout));
      check($sformatf("vec%0d_ready_out", i), 32'(ready_out), 32'(tbl[i].rdy));
      check($sformatf("vec%0d_dec_cnt", i),   32'(dec_cnt),   32'(tbl[i].cnt));
      check($sformatf("vec%0d_dec_cnt_w", i), 32'(dec_cnt_w), 32'(tbl[i].cnt[3:0]));
    end

    // Fill both entries with 1 and 2, then reset while full.
    ready_in = 1'b0; valid_in = 1'b1; d = 3'd1;
    step();
    d = 3'd2;
    step();
    check("full_ready_out", 32'(ready_out), 32'd0);
    check("full_q",         32'(q),         32'h02);
    rst = 1'b1; d = 3'd4; ready_in = 1'b1;
    step();
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_q",         32'(q),         32'h00);
    check("midrst_ready_out", 32'(ready_out), 32'd1);
    check("midrst_dec_cnt",   32'(dec_cnt),   32'd0);
    rst = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("postrst%0d_valid_out", i), 32'(valid_out), 32'd0);
      check($sformatf("postrst%0d_q", i),         32'(q),         32'h00);
    end
    check("postrst_dec_cnt", 32'(dec_cnt), 32'd0);

    // 17 words back-to-back: 16-bit counter reads 17, 4-bit counter wraps to 1.
    ready_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      valid_in = 1'b1;
      d        = 3'(i);
      step();
    end
    valid_in = 1'b0;
    step();
    check("wrap_dec_cnt16", 32'(dec_cnt),   32'd17);
    check("wrap_dec_cnt4",  32'(dec_cnt_w), 32'd1);
    check("wrap_valid_out", 32'(valid_out), 32'd0);

`ifdef DECODER_PARITY_EN
    // D=3 has two ones: PAR=0 makes the total even (bad), PAR=1 makes it odd (good).
    valid_in = 1'b1; d = 3'd3; par = 1'b0;
    step();
    check("parbad_par_err",   32'(par_err),   32'd1);
    check("parbad_valid_out", 32'(valid_out), 32'd0);
    check("parbad_ready_out", 32'(ready_out), 32'd1);
    par = 1'b1;
    step();
    check("pargood_par_err",   32'(par_err),   32'd0);
    check("pargood_q",         32'(q),         32'h08);
    check("pargood_valid_out", 32'(valid_out), 32'd1);
    valid_in = 1'b0;
    step();
    check("par_dec_cnt", 32'(dec_cnt), 32'd18);
    check("par_q_idle",  32'(q),       32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
